// File: rtl/seq_pc_stack.sv
// seq_pc_stack: program counter sequencer with a LIFO return-address stack.
// Each fetch edge is followed by an execute edge. Commands (ret > call > jmp > en)
// are acted on only at execute edges.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   en, jmp, call, ret command requests, sampled at execute edges
//   target            jump/call destination
//   clr_err           synchronous clear of the sticky ovf/unf flags
//   pc, phase, sp     registered program counter, phase (1 = execute), stack occupancy
//   full, empty       decoded from sp
//   ovf, unf          sticky overflow / underflow flags
module seq_pc_stack #(
    parameter int unsigned AW    = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       jmp,
    input  logic                       call,
    input  logic                       ret,
    input  logic [AW-1:0]              target,
    input  logic                       clr_err,
    output logic [AW-1:0]              pc,
    output logic                       phase,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   stack [DEPTH];
    logic [AW-1:0]   pc_nxt;
    logic [AW-1:0]   pc_inc;
    logic [SPW-1:0]  sp_nxt;
    logic            push;
    logic            ovf_set;
    logic            unf_set;

    assign pc_inc = pc + AW'(1);
    assign full   = (sp == SPW'(DEPTH));
    assign empty  = (sp == '0);
    assign phase  = (state == S_EXEC);

    // Phase register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next phase and command decode; commands only matter in the execute phase
    always_comb begin
        state_nxt = S_FETCH;
        pc_nxt    = pc;
        sp_nxt    = sp;
        push      = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (state)
            S_FETCH: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                if (ret) begin
                    if (empty) begin
                        pc_nxt  = pc_inc;
                        unf_set = 1'b1;
                    end else begin
                        pc_nxt = stack[IW'(sp - SPW'(1))];
                        sp_nxt = sp - SPW'(1);
                    end
                end else if (call) begin
                    if (full) begin
                        pc_nxt  = pc_inc;
                        ovf_set = 1'b1;
                    end else begin
                        push   = 1'b1;
                        pc_nxt = target;
                        sp_nxt = sp + SPW'(1);
                    end
                end else if (jmp) begin
                    pc_nxt = target;
                end else if (en) begin
                    pc_nxt = pc_inc;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // PC, stack pointer and sticky flags; a new error event beats clr_err
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc  <= '0;
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            pc <= pc_nxt;
            sp <= sp_nxt;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (unf_set) begin
                unf <= 1'b1;
            end else if (clr_err) begin
                unf <= 1'b0;
            end
        end
    end

    // Return-address storage; entries at or above sp are never read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack[i] <= '0;
            end
        end else if (push) begin
            stack[IW'(sp)] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_seq_pc_stack.sv
// tb_seq_pc_stack: directed scenarios plus randomized commands checked against
// a queue-based reference model of the sequencer.
module tb_seq_pc_stack;

    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SPW   = $clog2(DEPTH + 1);
    localparam int          PMASK = (1 << AW) - 1;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           en = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0, clr_err = 1'b0;
    logic [AW-1:0]  target = '0;
    logic [AW-1:0]  pc;
    logic           phase;
    logic [SPW-1:0] sp;
    logic           full, empty, ovf, unf;

    int checks = 0;
    int errors = 0;

    // reference model state
    int ph_m, pc_m, ovf_m, unf_m;
    int q_m[$];

    seq_pc_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .en(en), .jmp(jmp), .call(call), .ret(ret),
        .target(target), .clr_err(clr_err), .pc(pc), .phase(phase), .sp(sp),
        .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        ph_m = 0; pc_m = 0; ovf_m = 0; unf_m = 0;
        q_m.delete();
    endtask

    // One clock edge; model follows the stated command rules
    task automatic step();
        int ovf_s, unf_s;
        @(posedge clock);
        ovf_s = 0; unf_s = 0;
        if (ph_m == 1) begin
            if (ret) begin
                if (q_m.size() == 0) begin pc_m = (pc_m + 1) & PMASK; unf_s = 1; end
                else pc_m = q_m.pop_back();
            end else if (call) begin
                if (q_m.size() == DEPTH) begin pc_m = (pc_m + 1) & PMASK; ovf_s = 1; end
                else begin q_m.push_back((pc_m + 1) & PMASK); pc_m = int'(target); end
            end else if (jmp) pc_m = int'(target);
            else if (en) pc_m = (pc_m + 1) & PMASK;
        end
        if (ovf_s == 1) ovf_m = 1; else if (clr_err) ovf_m = 0;
        if (unf_s == 1) unf_m = 1; else if (clr_err) unf_m = 0;
        ph_m = 1 - ph_m;
        #1;
    endtask

    // Advance through the next execute edge with the current inputs held
    task automatic do_exec();
        if (ph_m == 0) step();
        step();
    endtask

    task automatic idle();
        en = 0; jmp = 0; call = 0; ret = 0; clr_err = 0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        #2;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({pc, phase, sp, ovf, unf} !== '0) begin
            errors++; $display("FAIL reset_state: pc=%h phase=%b sp=%0d ovf=%b unf=%b, want all 0", pc, phase, sp, ovf, unf);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL reset_flags: empty=%b full=%b, want 1/0", empty, full);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_increment();
        apply_reset();
        en = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pc !== AW'(i / 2)) begin
                errors++; $display("FAIL incr_pc[%0d]: got %h want %h", i, pc, i / 2);
            end
            step();
            checks++;
            if (phase !== ((i % 2) == 0)) begin
                errors++; $display("FAIL incr_phase[%0d]: got %b want %b", i, phase, (i % 2) == 0);
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        idle(); jmp = 1; target = 12'hFFF;
        do_exec();
        checks++;
        if (pc !== 12'hFFF || sp !== 0) begin
            errors++; $display("FAIL wrap_jmp: pc=%h sp=%0d want fff/0", pc, sp);
        end
        idle(); en = 1;
        do_exec();
        checks++;
        if (pc !== 12'h000 || sp !== 0) begin
            errors++; $display("FAIL wrap_en: pc=%h sp=%0d want 000/0", pc, sp);
        end
        idle();
    endtask

    task automatic test_call_ret();
        apply_reset();
        jmp = 1; target = 12'h010; do_exec();
        idle(); call = 1; target = 12'h100; do_exec();
        target = 12'h200; do_exec();
        checks++;
        if (pc !== 12'h200 || sp !== 2) begin
            errors++; $display("FAIL call2: pc=%h sp=%0d want 200/2", pc, sp);
        end
        idle(); ret = 1; do_exec();
        checks++;
        if (pc !== 12'h101 || sp !== 1) begin
            errors++; $display("FAIL ret1: pc=%h sp=%0d want 101/1", pc, sp);
        end
        do_exec();
        checks++;
        if (pc !== 12'h011 || sp !== 0 || empty !== 1'b1) begin
            errors++; $display("FAIL ret2: pc=%h sp=%0d empty=%b want 011/0/1", pc, sp, empty);
        end
        idle();
    endtask

    task automatic test_overflow();
        idle(); call = 1;
        for (int i = 0; i < 4; i++) begin
            target = AW'(12'h300 + i);
            do_exec();
        end
        checks++;
        if (sp !== 4 || full !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_fill: sp=%0d full=%b ovf=%b want 4/1/0", sp, full, ovf);
        end
        target = 12'h400; do_exec();
        checks++;
        if (pc !== 12'h304 || sp !== 4 || ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_fifth: pc=%h sp=%0d ovf=%b want 304/4/1", pc, sp, ovf);
        end
        idle(); clr_err = 1; step();
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: ovf=%b want 0", ovf);
        end
        call = 1; do_exec();
        checks++;
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_set_wins: ovf=%b want 1", ovf);
        end
        idle();
    endtask

    task automatic test_underflow_priority();
        apply_reset();
        ret = 1; do_exec();
        checks++;
        if (unf !== 1'b1 || pc !== 12'h001 || sp !== 0) begin
            errors++; $display("FAIL unf: unf=%b pc=%h sp=%0d want 1/001/0", unf, pc, sp);
        end
        idle(); clr_err = 1; step();
        checks++;
        if (unf !== 1'b0) begin
            errors++; $display("FAIL unf_clear: unf=%b want 0", unf);
        end
        idle(); call = 1; target = 12'h050; do_exec();
        idle(); ret = 1; call = 1; jmp = 1; en = 1; target = 12'h777; do_exec();
        checks++;
        if (pc !== 12'h002 || sp !== 0 || ovf !== 1'b0) begin
            errors++; $display("FAIL priority: pc=%h sp=%0d ovf=%b want 002/0/0", pc, sp, ovf);
        end
        idle();
    endtask

    task automatic test_async_reset();
        apply_reset();
        call = 1;
        for (int i = 0; i < 3; i++) begin
            target = AW'(12'h020 + i); do_exec();
        end
        idle(); jmp = 1; target = 12'h0A5; do_exec();
        checks++;
        if (pc !== 12'h0A5 || sp !== 3) begin
            errors++; $display("FAIL areset_setup: pc=%h sp=%0d want 0a5/3", pc, sp);
        end
        idle(); call = 1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({pc, phase, sp, ovf, unf} !== '0 || empty !== 1'b1) begin
            errors++; $display("FAIL areset_async: pc=%h phase=%b sp=%0d ovf=%b unf=%b empty=%b want 0s/empty", pc, phase, sp, ovf, unf, empty);
        end
        @(posedge clock); #1;
        idle(); reset = 1'b0; model_reset();
        ret = 1; do_exec();
        checks++;
        if (unf !== 1'b1 || pc !== 12'h001 || sp !== 0) begin
            errors++; $display("FAIL areset_ret: unf=%b pc=%h sp=%0d want 1/001/0", unf, pc, sp);
        end
        idle();
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            ret     = ($urandom_range(0, 99) < 30);
            call    = ($urandom_range(0, 99) < 35);
            jmp     = ($urandom_range(0, 99) < 20);
            en      = ($urandom_range(0, 99) < 60);
            clr_err = ($urandom_range(0, 99) < 10);
            target  = AW'($urandom);
            step();
            checks++;
            if (pc !== AW'(pc_m) || phase !== (ph_m == 1) || sp !== SPW'(q_m.size())) begin
                errors++; $display("FAIL rand_state[%0d]: pc=%h phase=%b sp=%0d want %h/%0d/%0d", n, pc, phase, sp, pc_m, ph_m, q_m.size());
            end
            checks++;
            if (full !== (q_m.size() == DEPTH) || empty !== (q_m.size() == 0) || ovf !== (ovf_m == 1) || unf !== (unf_m == 1)) begin
                errors++; $display("FAIL rand_flags[%0d]: full=%b empty=%b ovf=%b unf=%b want size=%0d ovf=%0d unf=%0d", n, full, empty, ovf, unf, q_m.size(), ovf_m, unf_m);
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_increment();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_underflow_priority();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
